// File: rtl/tilt_move_gen_if.sv
// Accelerometer-sample-in / movement-pulse-out bundle for tilt_move_gen.
interface tilt_move_gen_if;
    logic               enable;
    logic signed [11:0] accel_x;
    logic signed [11:0] accel_y;
    logic               accel_valid;
    logic [3:0]         movement;
    logic [3:0]         tilt_dir;

    modport master (
        output enable, accel_x, accel_y, accel_valid,
        input  movement, tilt_dir
    );

    modport slave (
        input  enable, accel_x, accel_y, accel_valid,
        output movement, tilt_dir
    );
endinterface

// File: rtl/tilt_move_gen.sv
// Turns latched X/Y tilt samples into rate-proportional, gap-limited one-hot
// movement pulses (0001 UP, 0010 DOWN, 0100 LEFT, 1000 RIGHT).
module tilt_move_gen #(
    parameter int unsigned CLK_FREQUENCY_HZ = 100_000_000,
    parameter int unsigned TICK_DIV         = 100_000,
    parameter int unsigned DEADZONE         = 64,
    parameter int unsigned STEP_THRESHOLD   = 4096,
    parameter int unsigned MIN_PULSE_GAP    = 128,
    parameter int unsigned ACC_W            = 16
) (
    input  logic           clk_i,
    input  logic           reset_i,
    tilt_move_gen_if.slave bus
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GAP_W  = $clog2(MIN_PULSE_GAP);
    localparam int unsigned SUM_W  = ACC_W + 1;

    // Elaboration-time guard against parameter sets the datapath cannot hold.
    if (MIN_PULSE_GAP < 2 || TICK_DIV < 1 || ACC_W < 12 || CLK_FREQUENCY_HZ == 0) begin : g_bad_params
        $error("tilt_move_gen: illegal parameter set");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GAP  = 1'b1
    } state_e;

    state_e            state_q;
    logic [TICK_W-1:0] tick_q;
    logic [GAP_W-1:0]  gap_q;
    logic              pri_q;        // 1 = Y axis wins the next tie
    logic [3:0]        movement_q;
    logic [3:0]        tilt_q;

    logic              tick_wrap_c;
    logic [1:0]        pend_c;       // per-axis pending step, [0]=X [1]=Y
    logic [1:0]        pdir_neg_c;   // per-axis latched step direction is negative
    logic [1:0]        serve_c;      // axis being issued this cycle
    logic [3:0]        tilt_c;

    assign tick_wrap_c = (tick_q == TICK_W'(TICK_DIV - 1));

    // Issue arbitration: a lone pending axis goes, a tie goes to the axis not last served.
    assign serve_c[0] = (state_q == S_IDLE) && bus.enable && pend_c[0] && (!pend_c[1] || !pri_q);
    assign serve_c[1] = (state_q == S_IDLE) && bus.enable && pend_c[1] && (!pend_c[0] ||  pri_q);

    for (genvar a = 0; a < 2; a++) begin : g_axis
        // X drives LEFT/RIGHT (bits 2/3), Y drives UP/DOWN (bits 0/1); low bit = negative tilt.
        localparam int unsigned BASE = (a == 0) ? 2 : 0;

        logic [11:0]      smp_q;
        logic             sgn_have_q;
        logic             sgn_neg_q;
        logic             pend_q;
        logic             pdir_neg_q;
        logic [ACC_W-1:0] acc_q;

        logic [ACC_W-1:0] acc_d;
        logic             pend_d;
        logic             pdir_neg_d;

        logic [11:0]      in_c;
        logic [11:0]      in_mag_c;
        logic             in_active_c;
        logic             flip_c;
        logic [11:0]      mag_c;
        logic [11:0]      excess_c;
        logic [SUM_W-1:0] sum_c;
        logic [ACC_W-1:0] sat_c;

        assign in_c        = (a == 0) ? bus.accel_x : bus.accel_y;
        assign in_mag_c    = in_c[11] ? 12'(-in_c) : in_c;
        assign in_active_c = (in_mag_c > 12'(DEADZONE));
        // A new out-of-deadzone sample pointing the other way discards built-up motion.
        assign flip_c      = bus.accel_valid && in_active_c && sgn_have_q && (in_c[11] != sgn_neg_q);

        assign mag_c    = smp_q[11] ? 12'(-smp_q) : smp_q;
        assign excess_c = (mag_c > 12'(DEADZONE)) ? (mag_c - 12'(DEADZONE)) : 12'd0;
        assign sum_c    = {1'b0, acc_q} + SUM_W'(excess_c);
        assign sat_c    = sum_c[ACC_W] ? {ACC_W{1'b1}} : sum_c[ACC_W-1:0];

        // Accumulator / pending-step next state.
        always_comb begin
            acc_d      = acc_q;
            pend_d     = pend_q;
            pdir_neg_d = pdir_neg_q;
            if (!bus.enable || flip_c) begin
                acc_d  = '0;
                pend_d = 1'b0;
            end else begin
                if (serve_c[a]) begin
                    pend_d = 1'b0;
                end
                if (tick_wrap_c) begin
                    if (excess_c == 12'd0) begin
                        acc_d = '0;
                    end else if ((sat_c >= ACC_W'(STEP_THRESHOLD)) && !pend_q) begin
                        acc_d      = sat_c - ACC_W'(STEP_THRESHOLD);
                        pend_d     = 1'b1;
                        pdir_neg_d = smp_q[11];
                    end else begin
                        acc_d = sat_c;
                    end
                end
            end
        end

        // Sample latch, sign history and accumulator state.
        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
                smp_q      <= '0;
                sgn_have_q <= 1'b0;
                sgn_neg_q  <= 1'b0;
                acc_q      <= '0;
                pend_q     <= 1'b0;
                pdir_neg_q <= 1'b0;
            end else begin
                if (bus.accel_valid) begin
                    smp_q <= in_c;
                end
                if (bus.accel_valid && in_active_c) begin
                    sgn_have_q <= 1'b1;
                    sgn_neg_q  <= in_c[11];
                end
                acc_q      <= acc_d;
                pend_q     <= pend_d;
                pdir_neg_q <= pdir_neg_d;
            end
        end

        assign pend_c[a]        = pend_q;
        assign pdir_neg_c[a]    = pdir_neg_q;
        assign tilt_c[BASE]     = (excess_c != 12'd0) &&  smp_q[11];
        assign tilt_c[BASE + 1] = (excess_c != 12'd0) && !smp_q[11];
    end

    // Tick divider, tilt level register and the pulse/gap FSM.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            gap_q      <= '0;
            pri_q      <= 1'b0;
            movement_q <= '0;
            tilt_q     <= '0;
        end else begin
            tilt_q     <= tilt_c;
            tick_q     <= tick_wrap_c ? '0 : (tick_q + TICK_W'(1));
            movement_q <= '0;
            if (!bus.enable) begin
                state_q <= S_IDLE;
                gap_q   <= '0;
                pri_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (serve_c[0] || serve_c[1]) begin
                            if (serve_c[0]) begin
                                movement_q <= pdir_neg_c[0] ? 4'b0100 : 4'b1000;
                            end else begin
                                movement_q <= pdir_neg_c[1] ? 4'b0001 : 4'b0010;
                            end
                            pri_q   <= serve_c[0];
                            gap_q   <= GAP_W'(MIN_PULSE_GAP - 1);
                            state_q <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        // Leaving on the 1->0 step lets IDLE fire exactly MIN_PULSE_GAP clocks later.
                        if (gap_q <= GAP_W'(1)) begin
                            gap_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            gap_q <= gap_q - GAP_W'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.movement = movement_q;
    assign bus.tilt_dir = tilt_q;

endmodule
